// File: rtl/mem_acc_cont_pkg.sv
// Shared types for the core memory access controller: line requests, NoC packet
// layout, memory payload formats, packet-type codes and the controller FSM states.
package mem_acc_cont_pkg;

  localparam int PRT_W      = 4;
  localparam int NOC_ADDR_W = 8;
  localparam int NOC_PORT_W = 4;
  localparam int NOC_DAT_W  = 256;

  localparam logic [7:0] memory_read_request  = 8'h01;
  localparam logic [7:0] memory_write_request = 8'h02;
  localparam logic [7:0] memory_read_reply    = 8'h03;

  typedef struct packed {
    logic [31:0]      addr;
    logic [127:0]     dat;
    logic [15:0]      wmsk;
    logic             rqt;
    logic [PRT_W-1:0] prt;
  } line_acc_req;

  typedef struct packed {
    logic [15:0]           len;
    logic [NOC_ADDR_W-1:0] src_addr;
    logic [NOC_PORT_W-1:0] src_port;
    logic [NOC_ADDR_W-1:0] dst_addr;
    logic [NOC_PORT_W-1:0] dst_port;
  } noc_hdr_t;

  typedef struct packed {
    noc_hdr_t             hdr;
    logic [NOC_DAT_W-1:0] dat;
  } noc_pkt_t;

  // Payloads sit at the bottom of noc_pkt_t.dat; the last field is the LSB (type byte)
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  typ;
  } mem_rd_rq;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [7:0]   typ;
  } mem_rd_rp;

  typedef struct packed {
    logic [15:0]  wmsk;
    logic [127:0] data;
    logic [31:0]  addr;
    logic [7:0]   typ;
  } mem_wr_rq;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } cmac_state_t;

  function automatic logic [PRT_W-1:0] oh2idx(input logic [15:0] oh);
    logic [PRT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | PRT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_acc_cont_if.sv
// NoC IP port: own address/port, transmit and receive packet handshakes.
interface noc_ip_port;
  import mem_acc_cont_pkg::*;

  logic [NOC_ADDR_W-1:0] prt_addr;
  logic [NOC_PORT_W-1:0] prt_num;
  logic                  tx_av;
  noc_pkt_t              tx_dat;
  logic                  tx_re;
  logic                  rx_av;
  noc_pkt_t              rx_dat;
  logic                  rx_re;

  modport ip_side (
    input  prt_addr, prt_num, tx_re, rx_av, rx_dat,
    output tx_av, tx_dat, rx_re
  );

  modport net_side (
    output prt_addr, prt_num, tx_re, rx_av, rx_dat,
    input  tx_av, tx_dat, rx_re
  );
endinterface

// File: rtl/mem_acc_cont_arb.sv
// Port arbiter: first requester at or above the pointer wins, wrapping to the
// lowest requester; a pointer tied to zero gives fixed lowest-index priority.
module mac_port_arbiter #(
  parameter int NUM_PRTS = 2,
  parameter int PTR_W    = 1
) (
  input  logic [NUM_PRTS-1:0] i_req,
  input  logic [PTR_W-1:0]    i_ptr,
  output logic [NUM_PRTS-1:0] o_gnt
);

  logic [NUM_PRTS-1:0] w_mask;
  logic [NUM_PRTS-1:0] w_hi;

  // Isolate the lowest set bit of the upper (at/after pointer) requests, else of all
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_PRTS; i++) begin
      w_mask[i] = (PTR_W'(i) >= i_ptr);
    end
    w_hi = i_req & w_mask;
    if (|w_hi) begin
      o_gnt = w_hi & (~w_hi + NUM_PRTS'(1'b1));
    end else begin
      o_gnt = i_req & (~i_req + NUM_PRTS'(1'b1));
    end
  end

endmodule

// File: rtl/mem_acc_cont.sv
// Core memory access controller: arbitrates core line requests onto one NoC port.
// Define CMAC_RR_ARB_EN for round-robin arbitration; otherwise lowest port wins.
module mem_acc_cont
  import mem_acc_cont_pkg::*;
#(
  parameter int NUM_PRTS     = 2,
  parameter int MEM_NOC_ADDR = 0,
  parameter int MEM_NOC_PORT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic        [NUM_PRTS-1:0] inp_rp,
  input  line_acc_req [NUM_PRTS-1:0] inp_req,
  output logic        [NUM_PRTS-1:0] inp_op,
  output logic        [NUM_PRTS-1:0] oup_rp,
  output line_acc_req [NUM_PRTS-1:0] oup_req,
  input  logic        [NUM_PRTS-1:0] oup_op,
  noc_ip_port.ip_side                noc
);

  localparam int PTR_W = (NUM_PRTS > 1) ? $clog2(NUM_PRTS) : 1;

  cmac_state_t                r_state;
  line_acc_req                r_req;
  logic                       r_reply_held;
  logic                       r_tx_av;
  noc_pkt_t                   r_tx_dat;
  logic        [NUM_PRTS-1:0] r_oup_rp;
  line_acc_req [NUM_PRTS-1:0] r_oup_req;

  logic        [PTR_W-1:0]    w_ptr;
  logic        [NUM_PRTS-1:0] w_gnt;
  logic        [PRT_W-1:0]    w_gnt_idx;
  logic        [PTR_W-1:0]    w_sel;
  logic                       w_accept;
  logic                       w_tx_fire;
  logic                       w_cap;
  mem_rd_rp                   w_rp;
  line_acc_req                w_sel_req;
  noc_pkt_t                   w_pkt;
  line_acc_req                w_ret_req;
  logic        [NUM_PRTS-1:0] w_ret_oh;
  line_acc_req [NUM_PRTS-1:0] w_ret_vec;

  mac_port_arbiter #(.NUM_PRTS(NUM_PRTS), .PTR_W(PTR_W)) u_arb (
    .i_req (inp_rp),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  assign w_gnt_idx = oh2idx(16'(w_gnt));
  assign w_sel     = w_gnt_idx[PTR_W-1:0];
  assign w_accept  = !rst && (r_state == ST_IDLE) && (|inp_rp);
  assign inp_op    = w_accept ? w_gnt : '0;
  assign w_tx_fire = r_tx_av && noc.tx_re;

  // Only a read reply for the in-flight address is taken; everything else stays queued
  assign w_rp  = noc.rx_dat.dat[$bits(mem_rd_rp)-1:0];
  assign w_cap = !rst && ((r_state == ST_SEND) || (r_state == ST_WAIT)) && !r_req.rqt &&
                 !r_reply_held && noc.rx_av && (w_rp.typ == memory_read_reply) &&
                 (w_rp.addr == r_req.addr);
  assign noc.rx_re = w_cap;

  assign noc.tx_av  = r_tx_av;
  assign noc.tx_dat = r_tx_dat;
  assign oup_rp     = r_oup_rp;
  assign oup_req    = r_oup_req;

`ifdef CMAC_RR_ARB_EN
  logic [PTR_W-1:0] r_ptr;

  // Pointer moves just past the port granted on each accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gnt_idx == PRT_W'(NUM_PRTS - 1)) ? '0 : PTR_W'(w_gnt_idx + PRT_W'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Packet is formed from the granted request so tx_dat is registered on accept
  always_comb begin
    w_sel_req             = inp_req[w_sel];
    w_pkt                 = '0;
    w_pkt.hdr.src_addr    = noc.prt_addr;
    w_pkt.hdr.src_port    = noc.prt_num;
    w_pkt.hdr.dst_addr    = NOC_ADDR_W'(MEM_NOC_ADDR);
    w_pkt.hdr.dst_port    = NOC_PORT_W'(MEM_NOC_PORT);
    w_pkt.dat[39:8]       = w_sel_req.addr;
    if (w_sel_req.rqt) begin
      w_pkt.hdr.len       = 16'($bits(noc_hdr_t) + $bits(mem_wr_rq));
      w_pkt.dat[7:0]      = memory_write_request;
      w_pkt.dat[167:40]   = w_sel_req.dat;
      w_pkt.dat[183:168]  = w_sel_req.wmsk;
    end else begin
      w_pkt.hdr.len       = 16'($bits(noc_hdr_t) + $bits(mem_rd_rq));
      w_pkt.dat[7:0]      = memory_read_request;
    end
  end

  // Completed request (with a same-cycle reply folded in) steered to its origin port
  always_comb begin
    w_ret_req = r_req;
    if (w_cap) begin
      w_ret_req.dat = w_rp.data;
    end else begin
      w_ret_req.dat = r_req.dat;
    end
    w_ret_oh  = '0;
    w_ret_vec = '0;
    for (int i = 0; i < NUM_PRTS; i++) begin
      if (r_req.prt == PRT_W'(i)) begin
        w_ret_oh[i]  = 1'b1;
        w_ret_vec[i] = w_ret_req;
      end else begin
        w_ret_oh[i]  = 1'b0;
        w_ret_vec[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_reply_held <= 1'b0;
      r_tx_av      <= 1'b0;
      r_tx_dat     <= '0;
      r_oup_rp     <= '0;
      r_oup_req    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req        <= w_sel_req;
            r_req.prt    <= w_gnt_idx;
            r_reply_held <= 1'b0;
            r_tx_av      <= 1'b1;
            r_tx_dat     <= w_pkt;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_cap) begin
            r_req.dat    <= w_rp.data;
            r_reply_held <= 1'b1;
          end
          if (w_tx_fire) begin
            r_tx_av  <= 1'b0;
            r_tx_dat <= '0;
            if (r_req.rqt || r_reply_held || w_cap) begin
              r_oup_rp  <= w_ret_oh;
              r_oup_req <= w_ret_vec;
              r_state   <= ST_RETURN;
            end else begin
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_cap) begin
            r_req.dat    <= w_rp.data;
            r_reply_held <= 1'b1;
            r_oup_rp     <= w_ret_oh;
            r_oup_req    <= w_ret_vec;
            r_state      <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          if (|(oup_op & r_oup_rp)) begin
            r_oup_rp  <= '0;
            r_oup_req <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_acc_cont.sv
// Self-checking bench for mem_acc_cont: queue-based core ports, a reactive memory
// on the NoC side and a transaction-level reference of arbitration and returns.
module tb_mem_acc_cont;
  import mem_acc_cont_pkg::*;

  localparam int         NP    = 2;
  localparam logic [7:0] MEM_A = 8'h21;
  localparam logic [3:0] MEM_P = 4'h2;
  localparam logic [7:0] OWN_A = 8'h5A;
  localparam logic [3:0] OWN_P = 4'h3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic        [NP-1:0] inp_rp;
  line_acc_req [NP-1:0] inp_req;
  logic        [NP-1:0] inp_op;
  logic        [NP-1:0] oup_rp;
  line_acc_req [NP-1:0] oup_req;
  logic        [NP-1:0] oup_op;

  int          checks = 0;
  int          errors = 0;
  int          mptr   = 0;
  int          ret_cnt [NP];
  line_acc_req pq [NP][$];

  noc_ip_port noc ();

  mem_acc_cont #(.NUM_PRTS(NP), .MEM_NOC_ADDR(33), .MEM_NOC_PORT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .inp_rp  (inp_rp),
    .inp_req (inp_req),
    .inp_op  (inp_op),
    .oup_rp  (oup_rp),
    .oup_req (oup_req),
    .oup_op  (oup_op),
    .noc     (noc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int g);
    logic [NP-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      inp_rp[p]  = (pq[p].size() > 0);
      inp_req[p] = (pq[p].size() > 0) ? pq[p][0] : '0;
    end
  endtask

  // Winner among non-empty port queues
  function automatic int model_grant();
    int p;
    for (int k = 0; k < NP; k++) begin
`ifdef CMAC_RR_ARB_EN
      p = (mptr + k) % NP;
`else
      p = k;
`endif
      if (pq[p].size() > 0) return p;
    end
    return -1;
  endfunction

  function automatic line_acc_req rand_req();
    line_acc_req r;
    r.addr = $urandom & 32'hFFFF_FFF0;
    r.dat  = {$urandom, $urandom, $urandom, $urandom};
    r.wmsk = 16'($urandom);
    r.rqt  = 1'($urandom);
    r.prt  = 4'($urandom);
    return r;
  endfunction

  function automatic noc_pkt_t req_pkt(input line_acc_req r);
    noc_pkt_t k;
    k = '0;
    k.hdr.src_addr = OWN_A;
    k.hdr.src_port = OWN_P;
    k.hdr.dst_addr = MEM_A;
    k.hdr.dst_port = MEM_P;
    k.dat[39:8]    = r.addr;
    if (r.rqt) begin
      k.hdr.len         = 16'd224;
      k.dat[7:0]        = 8'h02;
      k.dat[167:40]     = r.dat;
      k.dat[183:168]    = r.wmsk;
    end else begin
      k.hdr.len         = 16'd80;
      k.dat[7:0]        = 8'h01;
    end
    return k;
  endfunction

  function automatic noc_pkt_t reply_pkt(input logic [31:0] a, input logic [127:0] d);
    noc_pkt_t k;
    k = '0;
    k.hdr.len      = 16'd208;
    k.hdr.src_addr = MEM_A;
    k.hdr.src_port = MEM_P;
    k.hdr.dst_addr = OWN_A;
    k.hdr.dst_port = OWN_P;
    k.dat[7:0]     = 8'h03;
    k.dat[135:8]   = d;
    k.dat[167:136] = a;
    return k;
  endfunction

  // One full transaction: grant, send (tx_re after tx_lat), reply (after rd_lat), return (stalled)
  task automatic run_txn(input int tx_lat, input int rd_lat, input int stall);
    int           g;
    int           cyc;
    line_acc_req  acc;
    line_acc_req  exp_ret;
    logic [127:0] d;
    noc_pkt_t     want;
    bit           rd, sent, got, rx_ok;
    @(negedge clk);
    drive_ports();
    #1;
    g = model_grant();
    chk("grant", inp_op, onehot(g));
    chk("idle_oup_rp", oup_rp, '0);
    if (g < 0) return;
    acc     = pq[g].pop_front();
    acc.prt = 4'(g);
`ifdef CMAC_RR_ARB_EN
    mptr = (g + 1) % NP;
`endif
    rd      = !acc.rqt;
    d       = {$urandom, $urandom, $urandom, $urandom};
    want    = req_pkt(acc);
    exp_ret = acc;
    if (rd) exp_ret.dat = d;
    sent = 1'b0;
    got  = 1'b0;
    cyc  = 0;
    while (!(sent && (!rd || got)) && cyc < 20) begin
      @(negedge clk);
      drive_ports();
      noc.tx_re  = !sent && (cyc >= tx_lat);
      noc.rx_av  = 1'b0;
      noc.rx_dat = '0;
      rx_ok      = 1'b0;
      if (rd && !got && cyc >= rd_lat) begin
        noc.rx_av  = 1'b1;
        noc.rx_dat = reply_pkt(acc.addr, d);
        rx_ok      = 1'b1;
      end else if (rd && !got && cyc == rd_lat - 1) begin
        noc.rx_av  = 1'b1;
        noc.rx_dat = reply_pkt(acc.addr + 32'h10, ~d);
      end else if (!rd && !sent) begin
        noc.rx_av  = 1'b1;
        noc.rx_dat = reply_pkt(acc.addr, d);
      end
      #1;
      chk("tx_av", noc.tx_av, !sent);
      if (!sent) chk("tx_dat", noc.tx_dat, want);
      chk("rx_re", noc.rx_re, rx_ok);
      chk("busy_inp_op", inp_op, '0);
      chk("busy_oup_rp", oup_rp, '0);
      if (noc.tx_re) sent = 1'b1;
      if (rx_ok) got = 1'b1;
      cyc++;
    end
    chk("txn_done", sent && (!rd || got), 1'b1);
    if (!(sent && (!rd || got))) return;
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      drive_ports();
      noc.tx_re  = 1'b0;
      noc.rx_av  = 1'b0;
      noc.rx_dat = '0;
      oup_op     = '1;
      if (s < stall) oup_op[g] = 1'b0;
      #1;
      chk("oup_rp", oup_rp, onehot(g));
      chk("oup_req", oup_req[g], exp_ret);
      chk("ret_inp_op", inp_op, '0);
      chk("ret_tx_av", noc.tx_av, 1'b0);
    end
    ret_cnt[g]++;
  endtask

  initial begin
    line_acc_req r;
    line_acc_req acc;
    rst          = 1'b1;
    inp_rp       = '0;
    inp_req      = '0;
    oup_op       = '0;
    noc.prt_addr = OWN_A;
    noc.prt_num  = OWN_P;
    noc.tx_re    = 1'b0;
    noc.rx_av    = 1'b0;
    noc.rx_dat   = '0;
    ret_cnt      = '{default: 0};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_inp_op", inp_op, '0);
    chk("rst_oup_rp", oup_rp, '0);
    chk("rst_oup_req", oup_req, '0);
    chk("rst_tx_av", noc.tx_av, 1'b0);
    chk("rst_tx_dat", noc.tx_dat, '0);
    chk("rst_rx_re", noc.rx_re, 1'b0);
    rst    = 1'b0;
    oup_op = '1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_tx_av", noc.tx_av, 1'b0);
      chk("idle_inp_op", inp_op, '0);
    end

    // Directed read, port 0, addr 0x10
    r      = rand_req();
    r.addr = 32'h10;
    r.rqt  = 1'b0;
    pq[0].push_back(r);
    run_txn(0, 0, 0);

    // Directed write, port 1
    r      = rand_req();
    r.addr = 32'd40;
    r.dat  = 128'd287753;
    r.wmsk = 16'hFFF0;
    r.rqt  = 1'b1;
    pq[1].push_back(r);
    run_txn(0, 0, 0);

    // Read with late reply and a 5-cycle return stall
    r     = rand_req();
    r.rqt = 1'b0;
    pq[0].push_back(r);
    run_txn(0, 2, 5);

    // Both ports continuously busy, 16 requests each
    ret_cnt = '{default: 0};
    for (int i = 0; i < 16; i++) begin
      pq[0].push_back(rand_req());
      pq[1].push_back(rand_req());
    end
    for (int n = 0; n < 40 && (pq[0].size() + pq[1].size()) > 0; n++) begin
      run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
    end
    chk("ret_cnt0", ret_cnt[0], 16);
    chk("ret_cnt1", ret_cnt[1], 16);

    // Reset while waiting for a read reply
    r     = rand_req();
    r.rqt = 1'b0;
    pq[1].push_back(r);
    @(negedge clk);
    drive_ports();
    #1;
    chk("wrst_grant", inp_op, onehot(model_grant()));
    acc = pq[1].pop_front();
    @(negedge clk);
    drive_ports();
    noc.tx_re = 1'b1;
    #1;
    chk("wrst_send", noc.tx_av, 1'b1);
    @(negedge clk);
    noc.tx_re = 1'b0;
    #1;
    chk("wrst_wait_tx_av", noc.tx_av, 1'b0);
    chk("wrst_wait_oup_rp", oup_rp, '0);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    mptr       = 0;
    noc.rx_av  = 1'b1;
    noc.rx_dat = reply_pkt(acc.addr, 128'h1234);
    #1;
    chk("post_rst_rx_re", noc.rx_re, 1'b0);
    chk("post_rst_oup_rp", oup_rp, '0);
    chk("post_rst_tx_av", noc.tx_av, 1'b0);
    chk("post_rst_tx_dat", noc.tx_dat, '0);
    chk("post_rst_inp_op", inp_op, '0);
    @(negedge clk);
    noc.rx_av  = 1'b0;
    noc.rx_dat = '0;
    #1;
    chk("post_rst_oup_rp2", oup_rp, '0);
    r     = rand_req();
    r.rqt = 1'b0;
    pq[0].push_back(r);
    run_txn(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
